count_history_fifo: RTL and testbench
=====================================

Name: count_history_fifo

Overview:
- Downstream consumer of the free-running 8-bit testbench counter.
- Samples `count_in` on each enabled clock edge into a DEPTH-entry circular buffer.
- Presents the history through a valid/ready read port, so a Verisocks-driven checker can drain it.
- Also flags counter wrap-around (all-ones -> 0) and keeps a wrap tally.

Parameters:
- DATA_W, 8, width of sampled count and of read data.
- DEPTH, 16, number of buffer entries; power of 2, >= 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  capture `count_in` this cycle.
- count_in  input  DATA_W  counter value from upstream.
- rd_ready  input  1  consumer accepts `rd_data` this cycle.
- rd_valid  output  1  buffer non-empty; `rd_data` is meaningful.
- rd_data  output  DATA_W  oldest stored sample (show-ahead).
- level  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- clr_ovf  input  1  clears the sticky overflow flag.
- overflow  output  1  sticky: a sample arrived while full.
- wrap_pulse  output  1  one-cycle pulse on a detected counter wrap.
- wrap_cnt  output  16  number of wraps detected, saturating.

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - Pointers = 0, level = 0, empty = 1, full = 0, rd_valid = 0.
  - overflow = 0, wrap_pulse = 0, wrap_cnt = 0, prev_vld = 0.
  - Memory contents are not reset; `rd_data` is don't-care while empty.
- Write = `sample_en`; accepted when not full, or when full and a read happens in the same cycle.
  - Stores `count_in` at wr_ptr; wr_ptr increments modulo DEPTH.
- Read = `rd_valid && rd_ready`; rd_ptr increments modulo DEPTH.
- `rd_data` = mem[rd_ptr], combinational from registered state.
- `rd_valid` = !empty.
- Latency: a write into an empty buffer gives rd_valid = 1 and rd_data = that sample on the next cycle.
- Level update: write only +1; read only -1; both or neither unchanged.
  - `full` and `empty` are derived from `level`, not from pointer equality.
- `rd_ready` while empty is ignored: no pointer or level change.
- Simultaneous read and write when empty: only the write takes effect.
- Write while full without a read: the sample is dropped (overflow policy without macro) and overflow is set.
  - overflow holds until `clr_ovf`; if set and clear occur in the same cycle, set wins.
- Wrap detection runs on accepted or dropped samples alike (every `sample_en`):
  - Registers prev = `count_in` and sets prev_vld = 1.
  - wrap_pulse = 1 for the next cycle only, when prev_vld && prev == all-ones && `count_in` == 0.
  - wrap_cnt increments with each wrap_pulse and saturates at 0xFFFF.
  - The first sample after reset never produces a wrap.
- Reset asserted mid-drain: all state returns to reset values immediately; no partial read completes.

Optional Feature:
- Macro: OVERWRITE_OLDEST_EN.
- Defined: a write while full and not reading overwrites the oldest entry.
  - Both wr_ptr and rd_ptr advance; level stays DEPTH.
  - overflow is still set, marking lost history.
- Undefined: the drop-new policy above.
- Port list is identical in both builds.

Test Plan:
1. Reset, then `sample_en` = 1 for 5 cycles with `count_in` = 0..4, `rd_ready` = 0 -> level = 5, rd_valid = 1, rd_data = 0, full = 0, overflow = 0.
2. From test 1, `rd_ready` = 1 for 5 cycles -> rd_data sequence 0,1,2,3,4; then empty = 1, rd_valid = 0; a further `rd_ready` changes nothing.
3. Fill 16 samples 10..25, then write 26 with `rd_ready` = 0 -> full = 1, overflow = 1.
   - Default build: drain gives 10..25.
   - With OVERWRITE_OLDEST_EN: drain gives 11..26.
   - Then pulse `clr_ovf` -> overflow = 0.
4. Full buffer, `sample_en` and `rd_ready` both high for 3 cycles -> level stays 16, overflow stays 0, oldest three entries consumed in order.
5. Sample sequence 254, 255, 0, 1 -> wrap_pulse high for exactly one cycle, the cycle after the 0 sample; wrap_cnt = 1.
   - Repeat 255, 0 another 3 times -> wrap_cnt = 4.
6. Assert rst_n = 0 asynchronously mid-drain with level = 7 -> on the same edge, level = 0, empty = 1, rd_valid = 0, wrap_cnt = 0, overflow = 0.
   - First post-reset sample of 0 -> no wrap_pulse.

Source files
------------

// File: rtl/count_history_fifo.sv
// count_history_fifo
// ------------------
// Keeps a DEPTH-entry history of an upstream free-running counter. Each cycle
// with sample_en high captures count_in into a circular buffer. The history is
// drained through a show-ahead valid/ready read port. Counter wrap-arounds
// (all-ones followed by zero) are flagged with a one-cycle pulse and counted.
//
// Handshake: a read transfer happens on a rising clk edge where
// rd_valid && rd_ready are both high. rd_valid is level != 0. rd_data always
// shows the oldest entry while rd_valid is high. rd_valid does not depend on
// rd_ready. rd_ready is ignored while the buffer is empty.
//
// Build option:
//   OVERWRITE_OLDEST_EN - when defined, a sample that arrives while the buffer
//                         is full (and no read is taking place) overwrites the
//                         oldest entry. When undefined, that sample is dropped.
//                         In both builds the overflow flag is set.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   sample_en    capture count_in this cycle
//   count_in     upstream counter value
//   rd_ready     consumer takes rd_data this cycle
//   rd_valid     buffer is non-empty
//   rd_data      oldest stored sample
//   level        number of stored entries, 0..DEPTH
//   full, empty  level == DEPTH, level == 0
//   clr_ovf      clears the sticky overflow flag
//   overflow     sticky flag: a sample arrived while the buffer was full
//   wrap_pulse   one-cycle pulse after a detected counter wrap
//   wrap_cnt     saturating tally of detected wraps
module count_history_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] count_in,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  input  logic              clr_ovf,
  output logic              overflow,
  output logic              wrap_pulse,
  output logic [15:0]       wrap_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic [DATA_W-1:0] prev;
  logic              prev_vld;

  logic rd_fire;
  logic wr_acc;
  logic full_hit;
  logic ow;
  logic mem_we;
  logic wrap_det;

  // full/empty come from the occupancy count. With the count, a full buffer
  // and an empty buffer look different even when the two pointers are equal.
  assign empty    = (level_q == '0);
  assign full     = (level_q == DEPTH_L);
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];
  assign level    = level_q;

  assign rd_fire  = rd_valid && rd_ready;
  // A full buffer can still take a sample if a slot is freed in the same cycle.
  assign wr_acc   = sample_en && (!full || rd_fire);
  assign full_hit = sample_en && full && !rd_fire;

`ifdef OVERWRITE_OLDEST_EN
  assign ow = full_hit;
`else
  assign ow = 1'b0;
`endif

  assign mem_we   = wr_acc || ow;
  assign wrap_det = sample_en && prev_vld && (prev == '1) && (count_in == '0);

  // Storage is not reset. Stale contents are never visible because rd_valid
  // gates them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= count_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      // When the oldest entry is overwritten, the read side moves past it.
      if (rd_fire || ow) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc, rd_fire})
        2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
        2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // If set and clear happen in the same cycle, set wins, so no loss of
  // history goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (full_hit) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Wrap detection looks at every sample, whether it was stored or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_vld   <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      wrap_pulse <= wrap_det;
      if (sample_en) begin
        prev     <= count_in;
        prev_vld <= 1'b1;
      end
      if (wrap_det && (wrap_cnt != 16'hFFFF)) begin
        wrap_cnt <= wrap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_count_history_fifo.sv
module tb_count_history_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          sample_en;
  logic [DW-1:0] count_in;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [4:0]    level;
  logic          full;
  logic          empty;
  logic          clr_ovf;
  logic          overflow;
  logic          wrap_pulse;
  logic [15:0]   wrap_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: history as a queue, plus flags.
  logic [DW-1:0] exp_q[$];
  bit            m_ovf;
  logic [DW-1:0] m_prev;
  bit            m_prev_vld;
  bit            m_wp;
  int            m_wcnt;

  count_history_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .count_in(count_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .full(full), .empty(empty), .clr_ovf(clr_ovf),
    .overflow(overflow), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf      = 1'b0;
    m_prev     = '0;
    m_prev_vld = 1'b0;
    m_wp       = 1'b0;
    m_wcnt     = 0;
  endtask

  // One clock edge of the behavioural rules, using the inputs held at the edge.
  task automatic model_update();
    int sz;
    bit rd;
    bit hit;
    sz  = exp_q.size();
    rd  = (sz > 0) && rd_ready;
    hit = sample_en && (sz == DEPTH) && !rd;
    if (rd) void'(exp_q.pop_front());
    if (sample_en) begin
      if (sz < DEPTH || rd) exp_q.push_back(count_in);
`ifdef OVERWRITE_OLDEST_EN
      else begin
        void'(exp_q.pop_front());
        exp_q.push_back(count_in);
      end
`endif
    end
    if (hit) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_wp = sample_en && m_prev_vld && (m_prev == 8'hFF) && (count_in == 8'h00);
    if (m_wp && m_wcnt < 65535) m_wcnt++;
    if (sample_en) begin
      m_prev     = count_in;
      m_prev_vld = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".level"}, 32'(level), 32'(exp_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_wp));
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(m_wcnt));
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the edge. The model and the compare use
  // the values that were held at the edge.
  task automatic drive(input string tag, input bit se, input logic [7:0] ci,
                       input bit rr, input bit co);
    sample_en = se;
    count_in  = ci;
    rd_ready  = rr;
    clr_ovf   = co;
    @(posedge clk);
    model_update();
    #1;
    compare_all(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".level"}, 32'(level), 0);
    check({tag, ".empty"}, 32'(empty), 1);
    check({tag, ".full"}, 32'(full), 0);
    check({tag, ".rd_valid"}, 32'(rd_valid), 0);
    check({tag, ".overflow"}, 32'(overflow), 0);
    check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 0);
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cnt8;
    int first;
    rst_n = 1'b0; sample_en = 1'b0; count_in = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: five samples, no reads
    for (int i = 0; i < 5; i++) drive("t1", 1'b1, 8'(i), 1'b0, 1'b0);
    check("t1.rd_data0", 32'(rd_data), 0);
    check("t1.level5", 32'(level), 5);

    // T2: drain, then an extra read while empty
    for (int i = 0; i < 5; i++) begin
      check("t2.seq", 32'(rd_data), 32'(i));
      drive("t2", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    drive("t2_extra", 1'b0, 8'h00, 1'b1, 1'b0);
    check("t2.empty", 32'(empty), 1);

    // T3: fill 10..25, then 26 while full
    for (int i = 10; i < 26; i++) drive("t3_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("t3.full", 32'(full), 1);
    drive("t3_ovf", 1'b1, 8'd26, 1'b0, 1'b0);
    check("t3.overflow", 32'(overflow), 1);
`ifdef OVERWRITE_OLDEST_EN
    first = 11;
`else
    first = 10;
`endif
    for (int i = 0; i < 16; i++) begin
      check("t3.drain", 32'(rd_data), 32'(first + i));
      drive("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    drive("t3_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("t3.ovf_clr", 32'(overflow), 0);

    // T4: full buffer with simultaneous read and write
    for (int i = 30; i < 46; i++) drive("t4_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t4.order", 32'(rd_data), 32'(30 + i));
      drive("t4_rw", 1'b1, 8'(46 + i), 1'b1, 1'b0);
    end
    check("t4.level16", 32'(level), 16);
    check("t4.ovf0", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) drive("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // T5: wrap detection
    drive("t5", 1'b1, 8'd254, 1'b0, 1'b0);
    drive("t5", 1'b1, 8'd255, 1'b0, 1'b0);
    check("t5.no_pulse_yet", 32'(wrap_pulse), 0);
    drive("t5", 1'b1, 8'd0, 1'b0, 1'b0);
    check("t5.pulse", 32'(wrap_pulse), 1);
    drive("t5", 1'b1, 8'd1, 1'b0, 1'b0);
    check("t5.pulse_gone", 32'(wrap_pulse), 0);
    check("t5.cnt1", 32'(wrap_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      drive("t5_rep", 1'b1, 8'd255, 1'b0, 1'b0);
      drive("t5_rep", 1'b1, 8'd0, 1'b0, 1'b0);
    end
    check("t5.cnt4", 32'(wrap_cnt), 4);

    // T6: asynchronous reset mid-drain at level 7
    for (int i = 0; i < 3; i++) drive("t6_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("t6.level7", 32'(level), 7);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    drive("t6_first", 1'b1, 8'd0, 1'b0, 1'b0);
    check("t6.no_wrap", 32'(wrap_pulse), 0);

    // Random phase: counter-like samples with occasional jumps to the wrap
    // point. The read probability drifts so the buffer visits full and empty.
    cnt8 = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      bit se;
      bit rr;
      bit co;
      int rd_pct;
      rd_pct = ((c / 200) % 2 == 0) ? 25 : 75;
      se = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < rd_pct);
      co = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 3) cnt8 = 8'd254;
      drive("rand", se, cnt8, rr, co);
      if (se) cnt8 = cnt8 + 8'd1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
